// File: rtl/ddr3_pkg.sv
// Constants shared between the DDR3 controller and its user-side loopback checker,
// plus the checker's own state encoding.
package ddr3_pkg;

  localparam int DQ_BITWIDTH           = 16;
  localparam int BANK_ADDRESS_BITWIDTH = 3;
  localparam int ADDRESS_BITWIDTH      = 14;

  localparam int NUM_OF_DDR_STATES     = 24;
  localparam int STATE_BITWIDTH        = $clog2(NUM_OF_DDR_STATES);
  localparam int STATE_WRITE_DATA      = 8;
  localparam int STATE_READ_DATA       = 11;

  typedef enum logic [2:0] {
    CHK_IDLE  = 3'd0,
    CHK_WRITE = 3'd1,
    CHK_READ  = 3'd2,
    CHK_DRAIN = 3'd3,
    CHK_DONE  = 3'd4
  } chk_state_e;

endpackage

// File: rtl/ddr3_loopback_traffic_checker_tag_pipe.sv
// Fixed-latency tag pipe: each accepted read pushes its expected word and address,
// which emerge exactly DEPTH cycles later alongside the returning read data.
module ddr3_read_tag_pipe #(
  parameter int DEPTH = 8,
  parameter int DQ_W  = ddr3_pkg::DQ_BITWIDTH,
  parameter int A_W   = ddr3_pkg::BANK_ADDRESS_BITWIDTH + ddr3_pkg::ADDRESS_BITWIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_valid,
  input  logic [DQ_W-1:0] push_expected,
  input  logic [A_W-1:0]  push_address,
  output logic            pop_valid,
  output logic [DQ_W-1:0] pop_expected,
  output logic [A_W-1:0]  pop_address,
  output logic            empty
);
  import ddr3_pkg::*;

  logic [DEPTH-1:0] vld_q;
  logic [DQ_W-1:0]  exp_q  [DEPTH];
  logic [A_W-1:0]   addr_q [DEPTH];

  // Only the valid bits are reset; payload is qualified by them.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= push_valid;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    exp_q[0]  <= push_expected;
    addr_q[0] <= push_address;
    for (int i = 1; i < DEPTH; i++) begin
      exp_q[i]  <= exp_q[i-1];
      addr_q[i] <= addr_q[i-1];
    end
  end

  assign pop_valid    = vld_q[DEPTH-1];
  assign pop_expected = exp_q[DEPTH-1];
  assign pop_address  = addr_q[DEPTH-1];
  assign empty        = ~|vld_q;

endmodule

// File: rtl/ddr3_loopback_traffic_checker.sv
// User-side loopback exerciser for the DDR3 controller: writes an incrementing
// pattern, reads it back, and reports done/pass, error count and first failing address.
module ddr3_loopback_traffic_checker #(
  parameter int DQ_BITWIDTH           = ddr3_pkg::DQ_BITWIDTH,
  parameter int BANK_ADDRESS_BITWIDTH = ddr3_pkg::BANK_ADDRESS_BITWIDTH,
  parameter int ADDRESS_BITWIDTH      = ddr3_pkg::ADDRESS_BITWIDTH,
  parameter int STATE_BITWIDTH        = ddr3_pkg::STATE_BITWIDTH,
  parameter int STATE_WRITE_DATA      = ddr3_pkg::STATE_WRITE_DATA,
  parameter int STATE_READ_DATA       = ddr3_pkg::STATE_READ_DATA,
  parameter int NUM_OF_TEST_DATA      = 4,
  parameter int START_ADDRESS         = 0,
  parameter int DATA_OFFSET           = 0,
  parameter int READ_LATENCY          = 8
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [STATE_BITWIDTH-1:0]                        main_state,
  input  logic [DQ_BITWIDTH-1:0]                           data_from_ram,
  output logic                                             write_enable,
  output logic                                             read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                           data_to_ram,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             pass,
  output logic [15:0]                                      error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);
  import ddr3_pkg::*;

  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int IW = AW + 1;
  localparam logic [IW-1:0]             LAST_IDX = IW'(NUM_OF_TEST_DATA - 1);
  localparam logic [AW-1:0]             START_A  = AW'(START_ADDRESS);
  localparam logic [DQ_BITWIDTH-1:0]    OFFSET   = DQ_BITWIDTH'(DATA_OFFSET);
  localparam logic [STATE_BITWIDTH-1:0] ST_WR    = STATE_BITWIDTH'(STATE_WRITE_DATA);
  localparam logic [STATE_BITWIDTH-1:0] ST_RD    = STATE_BITWIDTH'(STATE_READ_DATA);

  function automatic logic [DQ_BITWIDTH-1:0] pattern(input logic [IW-1:0] idx);
    return OFFSET + DQ_BITWIDTH'(idx);
  endfunction

  chk_state_e             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DQ_BITWIDTH-1:0] wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic [15:0]            err_q, err_d;
  logic [AW-1:0]          ferr_q, ferr_d;
  logic                   ferr_seen_q, ferr_seen_d;
  logic                   pass_q, pass_d;

  logic                   push_vld;
  logic [DQ_BITWIDTH-1:0] push_exp;
  logic                   pop_vld;
  logic [DQ_BITWIDTH-1:0] pop_exp;
  logic [AW-1:0]          pop_addr;
  logic                   pipe_empty;

  ddr3_read_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .DQ_W  (DQ_BITWIDTH),
    .A_W   (AW)
  ) u_tag_pipe (
    .clk           (clk),
    .reset         (reset),
    .push_valid    (push_vld),
    .push_expected (push_exp),
    .push_address  (addr_q),
    .pop_valid     (pop_vld),
    .pop_expected  (pop_exp),
    .pop_address   (pop_addr),
    .empty         (pipe_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CHK_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      err_q       <= '0;
      ferr_q      <= '0;
      ferr_seen_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      err_q       <= err_d;
      ferr_q      <= ferr_d;
      ferr_seen_q <= ferr_seen_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    re_d        = re_q;
    err_d       = err_q;
    ferr_d      = ferr_q;
    ferr_seen_d = ferr_seen_q;
    pass_d      = pass_q;
    push_vld    = 1'b0;
    push_exp    = pattern(idx_q);

    // Compare runs every cycle regardless of phase; the pipe alone decides when.
    if (pop_vld && (pop_exp != data_from_ram)) begin
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
      if (!ferr_seen_q) begin
        ferr_d      = pop_addr;
        ferr_seen_d = 1'b1;
      end
    end

    case (state_q)
      CHK_IDLE, CHK_DONE: begin
        if (start) begin
          err_d       = '0;
          ferr_d      = '0;
          ferr_seen_d = 1'b0;
          pass_d      = 1'b0;
          idx_d       = '0;
          addr_d      = START_A;
          wdata_d     = OFFSET;
          we_d        = 1'b1;
          state_d     = CHK_WRITE;
        end
      end
      CHK_WRITE: begin
        if (we_q && (main_state == ST_WR)) begin
          if (idx_q == LAST_IDX) begin
            we_d    = 1'b0;
            re_d    = 1'b1;
            addr_d  = START_A;
            idx_d   = '0;
            wdata_d = '0;
            state_d = CHK_READ;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            wdata_d = wdata_q + 1'b1;
          end
        end
      end
      CHK_READ: begin
        if (re_q && (main_state == ST_RD)) begin
          push_vld = 1'b1;
          idx_d    = idx_q + 1'b1;
          addr_d   = addr_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            re_d    = 1'b0;
            state_d = CHK_DRAIN;
          end
        end
      end
      CHK_DRAIN: begin
        // An empty pipe means the final compare already landed in err_q.
        if (pipe_empty) begin
          pass_d  = (err_q == 16'd0);
          state_d = CHK_DONE;
        end
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  assign write_enable        = we_q;
  assign read_enable         = re_q;
  assign i_user_data_address = addr_q;
  assign data_to_ram         = wdata_q;
  assign busy                = (state_q == CHK_WRITE) || (state_q == CHK_READ) ||
                               (state_q == CHK_DRAIN);
  assign done                = (state_q == CHK_DONE);
  assign pass                = pass_q;
  assign error_count         = err_q;
  assign first_error_address = ferr_q;

endmodule

// File: tb/tb_ddr3_loopback_traffic_checker.sv
// Loopback checker bench: a behavioural controller/memory stub drives main_state and
// returns read data at a fixed latency; a scoreboard predicts writes, reads and results.
module tb_ddr3_loopback_traffic_checker;

  localparam int N      = 4;
  localparam int L1     = 8;
  localparam int L2     = 3;
  localparam int START1 = 0;
  localparam int START2 = (1 << 17) - 2;
  localparam int OFF1   = 0;
  localparam int OFF2   = 16'hFFFE;
  localparam int AMASK  = (1 << 17) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start1, start2;
  logic [4:0]  ms1, ms2;
  logic [15:0] drf1, drf2;
  logic        we1, re1, busy1, done1, pass1;
  logic        we2, re2, busy2, done2, pass2;
  logic [16:0] addr1, addr2, ferr1, ferr2;
  logic [15:0] dout1, dout2, err1, err2;

  ddr3_loopback_traffic_checker #(
    .NUM_OF_TEST_DATA (N), .START_ADDRESS (START1), .DATA_OFFSET (OFF1), .READ_LATENCY (L1)
  ) dut (
    .clk (clk), .reset (reset), .start (start1), .main_state (ms1), .data_from_ram (drf1),
    .write_enable (we1), .read_enable (re1), .i_user_data_address (addr1),
    .data_to_ram (dout1), .busy (busy1), .done (done1), .pass (pass1),
    .error_count (err1), .first_error_address (ferr1)
  );

  ddr3_loopback_traffic_checker #(
    .NUM_OF_TEST_DATA (N), .START_ADDRESS (START2), .DATA_OFFSET (OFF2), .READ_LATENCY (L2)
  ) dut_wrap (
    .clk (clk), .reset (reset), .start (start2), .main_state (ms2), .data_from_ram (drf2),
    .write_enable (we2), .read_enable (re2), .i_user_data_address (addr2),
    .data_to_ram (dout2), .busy (busy2), .done (done2), .pass (pass2),
    .error_count (err2), .first_error_address (ferr2)
  );

  int sel;
  logic        we_m, re_m, busy_m, done_m, pass_m;
  logic [16:0] addr_m, ferr_m;
  logic [15:0] dout_m, err_m;
  assign we_m   = (sel != 0) ? we2   : we1;
  assign re_m   = (sel != 0) ? re2   : re1;
  assign busy_m = (sel != 0) ? busy2 : busy1;
  assign done_m = (sel != 0) ? done2 : done1;
  assign pass_m = (sel != 0) ? pass2 : pass1;
  assign addr_m = (sel != 0) ? addr2 : addr1;
  assign ferr_m = (sel != 0) ? ferr2 : ferr1;
  assign dout_m = (sel != 0) ? dout2 : dout1;
  assign err_m  = (sel != 0) ? err2  : err1;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  logic [15:0] due_data [int];
  logic [15:0] mem [int];
  int wcnt, rcnt, merr, mfirst, last_read_edge, mode, corrupt_idx;
  bit mfirst_seen, rand_corrupt, tgl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start2 = v; else start1 = v;
  endtask

  // One clock: drive stub inputs at the negedge, predict acceptances, advance.
  task automatic tick();
    logic [4:0]  ms;
    logic [15:0] rd, rd2, ex;
    int e, ea, ed, st, off, lat;
    st  = (sel != 0) ? START2 : START1;
    off = (sel != 0) ? OFF2 : OFF1;
    lat = (sel != 0) ? L2 : L1;
    case (mode)
      0: ms = (we_m === 1'b1) ? 5'd8 : ((re_m === 1'b1) ? 5'd11 : 5'd0);
      1: begin
        ms  = tgl ? ((re_m === 1'b1) ? 5'd11 : 5'd8) : 5'd0;
        tgl = !tgl;
      end
      default: begin
        case ($urandom_range(0, 3))
          0: ms = 5'd8;
          1: ms = 5'd11;
          2: ms = 5'd0;
          default: ms = 5'($urandom_range(0, 31));
        endcase
      end
    endcase
    e  = edge_cnt + 1;
    rd = due_data.exists(e) ? due_data[e] : 16'($urandom);
    if (sel != 0) begin
      ms2 = ms; drf2 = rd; ms1 = 5'd0; drf1 = 16'($urandom);
    end else begin
      ms1 = ms; drf1 = rd; ms2 = 5'd0; drf2 = 16'($urandom);
    end
    if (!reset) begin
      if (we_m === 1'b1 && ms == 5'd8) begin
        ea = (st + wcnt) & AMASK;
        ed = (off + wcnt) & 16'hFFFF;
        chk("wr_addr", 32'(addr_m), ea);
        chk("wr_data", 32'(dout_m), ed);
        mem[int'(addr_m)] = dout_m;
        wcnt++;
      end
      if (re_m === 1'b1 && ms == 5'd11) begin
        ea = (st + rcnt) & AMASK;
        ex = 16'(off + rcnt);
        chk("rd_addr", 32'(addr_m), ea);
        rd2 = mem.exists(int'(addr_m)) ? mem[int'(addr_m)] : 16'($urandom);
        if (rcnt == corrupt_idx) rd2 = 16'hDEAD;
        else if (rand_corrupt && $urandom_range(0, 2) == 0) rd2 = ex ^ 16'($urandom_range(1, 65535));
        due_data[e + lat] = rd2;
        if (rd2 != ex) begin
          merr++;
          if (!mfirst_seen) begin
            mfirst_seen = 1'b1;
            mfirst      = ea;
          end
        end
        rcnt++;
        if (rcnt == N) last_read_edge = e;
      end
    end
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
  endtask

  task automatic begin_run(input int s, input int md, input int cidx, input bit rc);
    sel = s; mode = md; corrupt_idx = cidx; rand_corrupt = rc;
    wcnt = 0; rcnt = 0; merr = 0; mfirst = 0; mfirst_seen = 1'b0;
    last_read_edge = -1; tgl = 1'b1;
    mem.delete();
  endtask

  task automatic run_test(input int s, input int md, input int cidx, input bit rc,
                          input bit hold, input bit skip_start);
    int bound, lat;
    begin_run(s, md, cidx, rc);
    lat = (s != 0) ? L2 : L1;
    if (!skip_start) begin
      set_start(1'b1);
      tick();
      if (!hold) set_start(1'b0);
      chk("start_we", 32'(we_m), 1);
      chk("start_busy", 32'(busy_m), 1);
      chk("start_done", 32'(done_m), 0);
    end
    bound = 0;
    while (done_m !== 1'b1 && bound < 3000) begin
      tick();
      bound++;
    end
    chk("done_seen", 32'(done_m), 1);
    chk("wr_count", wcnt, N);
    chk("rd_count", rcnt, N);
    chk("done_latency", edge_cnt, last_read_edge + lat + 1);
    chk("pass", 32'(pass_m), (merr == 0) ? 1 : 0);
    chk("error_count", 32'(err_m), merr);
    chk("first_err_addr", 32'(ferr_m), mfirst);
    chk("busy_in_done", 32'(busy_m), 0);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_we"}, 32'(we_m), 0);
    chk({pfx, "_re"}, 32'(re_m), 0);
    chk({pfx, "_addr"}, 32'(addr_m), 0);
    chk({pfx, "_data"}, 32'(dout_m), 0);
    chk({pfx, "_busy"}, 32'(busy_m), 0);
    chk({pfx, "_done"}, 32'(done_m), 0);
    chk({pfx, "_pass"}, 32'(pass_m), 0);
    chk({pfx, "_err"}, 32'(err_m), 0);
    chk({pfx, "_ferr"}, 32'(ferr_m), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bound;
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    ms1 = '0; ms2 = '0; drf1 = '0; drf2 = '0;
    begin_run(0, 0, -1, 1'b0);
    @(negedge clk);
    tick();
    tick();
    sel = 0; chk_zero("rst_dut");
    sel = 1; chk_zero("rst_wrap");
    reset = 1'b0;
    tick();

    // Clean run, then a run with the third read word corrupted.
    run_test(0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_test(0, 0, 2, 1'b0, 1'b0, 1'b0);
    chk("corrupt_err", 32'(err1), 1);
    chk("corrupt_ferr", 32'(ferr1), 2);
    chk("corrupt_pass", 32'(pass1), 0);

    // main_state toggling against an idle value every cycle.
    run_test(0, 1, -1, 1'b0, 1'b0, 1'b0);

    // Address wrap past all ones and pattern wrap past 16'hFFFF.
    run_test(1, 0, -1, 1'b0, 1'b0, 1'b0);

    // Randomised controller states and random read corruption.
    for (int k = 0; k < 6; k++) begin
      run_test(k % 2, 2, -1, 1'b1, 1'b0, 1'b0);
    end

    // Reset in the middle of the read phase, then a clean run.
    begin_run(0, 0, -1, 1'b0);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    bound = 0;
    while (rcnt < 2 && bound < 200) begin
      tick();
      bound++;
    end
    chk("mid_reset_reached_read", rcnt, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    due_data.delete();
    chk_zero("mid_reset");
    run_test(0, 0, -1, 1'b0, 1'b0, 1'b0);
    chk("after_reset_pass", 32'(pass1), 1);

    // start held high throughout: one restart only, from DONE.
    run_test(0, 0, 1, 1'b0, 1'b1, 1'b0);
    tick();
    start1 = 1'b0;
    chk("restart_we", 32'(we1), 1);
    chk("restart_busy", 32'(busy1), 1);
    chk("restart_done", 32'(done1), 0);
    chk("restart_err_clr", 32'(err1), 0);
    chk("restart_ferr_clr", 32'(ferr1), 0);
    chk("restart_addr", 32'(addr1), START1);
    run_test(0, 0, -1, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_loopback_traffic_checker.md
# ddr3_loopback_traffic_checker

Upstream user-side stimulus and checker for `ddr3_memory_controller`. It writes `NUM_OF_TEST_DATA` incrementing words to consecutive user addresses, then reads them back. Each returned word is compared against the expected pattern, and the block reports `done`, `pass`, an error count and the first failing address. It replaces ad-hoc loopback logic in board tops and Micron-model benches, and drives the controller's `write_enable`, `read_enable`, `i_user_data_address` and `data_to_ram` ports directly.

## Interface
Parameters:
- `DQ_BITWIDTH`, 16: data word width.
- `BANK_ADDRESS_BITWIDTH`, 3: bank bits in the user address.
- `ADDRESS_BITWIDTH`, 14: row/column bits in the user address.
- `STATE_BITWIDTH`, 5: width of the controller `main_state`.
- `STATE_WRITE_DATA`, 8: controller state in which a write is accepted.
- `STATE_READ_DATA`, 11: controller state in which a read is accepted.
- `NUM_OF_TEST_DATA`, 4: words per run; legal values are 1 to 2^(BANK+ADDR).
- `START_ADDRESS`, 0: user address of the first word.
- `DATA_OFFSET`, 0: pattern base; word i = DATA_OFFSET + i, modulo 2^DQ_BITWIDTH.
- `READ_LATENCY`, 8: clk cycles from read acceptance until `data_from_ram` is valid; legal values are at least 1.

Ports:
- `clk`, in, 1: the single clock. The block has one clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: level sampled per cycle; begins a run when the block is in IDLE or DONE.
- `main_state`, in, STATE_BITWIDTH: current controller state.
- `data_from_ram`, in, DQ_BITWIDTH: read data from the controller.
- `write_enable`, out, 1: write request.
- `read_enable`, out, 1: read request.
- `i_user_data_address`, out, BANK+ADDR: request address.
- `data_to_ram`, out, DQ_BITWIDTH: write data.
- `busy`, out, 1: high in WRITE, READ and DRAIN.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: high in DONE when `error_count` is 0.
- `error_count`, out, 16: number of mismatches; saturates at 16'hFFFF.
- `first_error_address`, out, BANK+ADDR: address of the first mismatch in the run.

## Operation
- States: IDLE → WRITE → READ → DRAIN → DONE. DONE moves back to WRITE on `start`.
- Reset: all outputs are 0; the state is IDLE; the tag pipe is cleared; the index counter is 0.
- IDLE or DONE with `start`:
  - clear `error_count` and `first_error_address`;
  - set index to 0, address to START_ADDRESS, data to DATA_OFFSET;
  - assert `write_enable`;
  - go to WRITE.
- `start` is ignored in WRITE, READ and DRAIN.
- Write acceptance happens in a cycle with `write_enable` high and `main_state == STATE_WRITE_DATA`. On that edge the index, address and data each increment by 1.
- On acceptance of the last write (index = NUM_OF_TEST_DATA-1), on the same edge:
  - `write_enable` goes to 0;
  - `read_enable` goes to 1;
  - address reloads to START_ADDRESS;
  - index goes to 0;
  - `data_to_ram` goes to 0;
  - state goes to READ.
- Read acceptance happens in a cycle with `read_enable` high and `main_state == STATE_READ_DATA`. Each acceptance:
  - pushes {valid=1, expected=DATA_OFFSET+index, address} into the tag pipe;
  - increments the index and address.
- On acceptance of the last read, `read_enable` goes to 0 and the state goes to DRAIN.
- Check: when a pipe entry emerges valid, compare it with `data_from_ram` in that cycle.
  - On mismatch, `error_count` increments with saturation.
  - On the first mismatch of a run, `first_error_address` captures the entry address.
- DRAIN moves to DONE in the cycle after the last valid entry has been checked, i.e. when the pipe is empty. `pass` is updated in the same cycle that `done` rises.
- Address arithmetic is modulo 2^(BANK+ADDR); a wrap past all ones goes to 0 silently. The pattern wraps modulo 2^DQ_BITWIDTH.
- Any other `main_state` value holds all requests and counters. The tag pipe keeps shifting in every cycle.
- Reset asserted mid-run aborts the run immediately and returns all outputs to their reset values; in-flight pipe entries are discarded. Reset has priority over `start` in the same cycle.

## Timing
- Request outputs are registered; there are no combinational paths from input to output.
- Write throughput: 1 word per cycle while `main_state` stays at STATE_WRITE_DATA.
- Read issue to compare: exactly READ_LATENCY cycles. The entry pushed at edge n is compared at edge n+READ_LATENCY.
- Back-to-back reads: the pipe accepts one entry per cycle with no stall, and its depth equals READ_LATENCY.
- `start` to first `write_enable`: 1 cycle.
- Last read acceptance to `done`: READ_LATENCY+1 cycles.

## Structure
- Shared package `ddr3_pkg` holds:
  - STATE_WRITE_DATA, STATE_READ_DATA, NUM_OF_DDR_STATES and STATE_BITWIDTH, shared with the controller;
  - DQ, ADDRESS and BANK bitwidth constants;
  - the checker state encoding.
- Sub-module `ddr3_read_tag_pipe`: a READ_LATENCY-deep shift register of {valid, expected, address}. It has `clk`, `reset`, push inputs, pop outputs and an `empty` flag.

## Test plan
- Controller stub holds `main_state`=8 for 4 cycles, then 11; READ_LATENCY=8; stub returns data = 16'h0000 + k. Required response: addresses 0-3 written with data 0-3, reads from address 0, `done`=1 and `pass`=1 at 9 cycles after the last read, `error_count`=0.
- Stub corrupts the third read word to 16'hDEAD. Required response: `error_count`=1, `first_error_address`=2, `pass`=0.
- `main_state` toggles between 8 and 0 every cycle. Required response: exactly 4 write acceptances with no skipped or duplicated addresses; data matches the address index.
- START_ADDRESS = 2^17-2, NUM_OF_TEST_DATA=4. Required response: addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 on both writes and reads.
- `reset` pulsed during READ. Required response: all outputs return to 0 next cycle. A subsequent `start` completes a clean run with `pass`=1, and no stale compare occurs.
- `start` held high through the whole run and into DONE. Required response: the run is not restarted while `busy`; the counters clear on the first cycle in DONE with `start`, and a second run begins.
